// File: rtl/mii_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// mii_frame_scheduler_if
//
// Purpose: groups the signals exchanged between the frame scheduler and the
// 64-bit MII frame generator.
//
// Signals:
//   i_gen_tx_data  [DATA_WIDTH] generator o_tx_data (generator -> scheduler)
//   i_gen_tx_ctrl  [CTRL_WIDTH] generator o_tx_ctrl (generator -> scheduler)
//   o_start        [1]          start pulse         (scheduler -> generator)
//   o_interrupt    [8]          interrupt code      (scheduler -> generator)
//
// Modports:
//   master : scheduler side
//   slave  : generator side
// ---------------------------------------------------------------------------
interface mii_frame_scheduler_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] i_gen_tx_data;
    logic [CTRL_WIDTH-1:0] i_gen_tx_ctrl;
    logic                  o_start;
    logic [7:0]            o_interrupt;

    modport master (
        input  i_gen_tx_data,
        input  i_gen_tx_ctrl,
        output o_start,
        output o_interrupt
    );

    modport slave (
        output i_gen_tx_data,
        output i_gen_tx_ctrl,
        input  o_start,
        input  o_interrupt
    );
endinterface

// File: rtl/mii_frame_scheduler.sv
// ---------------------------------------------------------------------------
// mii_frame_scheduler
//
// Purpose: sequences the 64-bit MII frame generator. Issues single-cycle
// start pulses with a per-frame interrupt code, detects end-of-frame from the
// generator's terminate block, inserts a programmable inter-frame gap and
// stops after a programmed number of frames (or runs continuously).
//
// Ports:
//   clk            clock, rising edge
//   i_rst          synchronous active-high reset
//   i_enable       run request (level)
//   i_frame_count  frames per run, 0 = continuous
//   i_gap_cycles   idle cycles between terminate and next start
//   i_err_mode     interrupt code used for errored frames
//   i_err_period   every Nth frame is errored, 0 = never
//   bus            generator link (tx data/ctrl in, start/interrupt out)
//   o_busy         high in START, WAIT_EOF and GAP
//   o_done         run complete (normally or by watchdog)
//   o_timeout      sticky: run aborted by the watchdog
//   o_frames_sent  terminates detected in the current run
//
// Build option:
//   MII_FRAME_SCHED_TIMEOUT_EN  when defined, a watchdog aborts WAIT_EOF after
//                               FRAME_TIMEOUT cycles; otherwise o_timeout is 0
//                               and WAIT_EOF waits indefinitely.
// ---------------------------------------------------------------------------
module mii_frame_scheduler #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter logic [7:0] TERMINATE_CODE = 8'hFD,
    parameter int         CNT_WIDTH      = 16,
    parameter int         GAP_WIDTH      = 8,
    parameter int         FRAME_TIMEOUT  = 128
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic [CNT_WIDTH-1:0] i_frame_count,
    input  logic [GAP_WIDTH-1:0] i_gap_cycles,
    input  logic [7:0]           i_err_mode,
    input  logic [7:0]           i_err_period,
    mii_frame_scheduler_if.master bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_frames_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_EOF,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] frame_count_reg;
    logic [GAP_WIDTH-1:0] gap_reg;
    logic [GAP_WIDTH-1:0] gap_cnt_reg;
    logic [7:0]           err_mode_reg;
    logic [7:0]           err_period_reg;
    logic [7:0]           err_cnt_reg;
    logic [7:0]           interrupt_reg;
    logic [CNT_WIDTH-1:0] frames_sent_reg;

    // Interrupt code and countdown for the frame about to start. The code is
    // registered on the transition into START so it is valid during the
    // start pulse. Leaving IDLE the run settings are being latched in the
    // same cycle, so they are taken straight from the inputs.
    logic [7:0]           sel_period;
    logic [7:0]           sel_mode;
    logic [7:0]           sel_cnt;
    logic [7:0]           interrupt_next;
    logic [7:0]           err_cnt_next;
    logic                 term_match;
    logic [CNT_WIDTH-1:0] frames_sent_next;

    always_comb begin
        sel_period = err_period_reg;
        sel_mode   = err_mode_reg;
        sel_cnt    = err_cnt_reg;
        if (state_reg == S_IDLE) begin
            sel_period = i_err_period;
            sel_mode   = i_err_mode;
            sel_cnt    = i_err_period;
        end
        interrupt_next = 8'h00;
        if (sel_period != 8'd0 && sel_cnt == 8'd1) begin
            interrupt_next = sel_mode;
        end
        err_cnt_next = (sel_cnt == 8'd1) ? sel_period : sel_cnt - 8'd1;

        term_match = (bus.i_gen_tx_ctrl == CTRL_WIDTH'(1)) &&
                     (bus.i_gen_tx_data[DATA_WIDTH-1 -: 8] == TERMINATE_CODE);
        frames_sent_next = frames_sent_reg + CNT_WIDTH'(1);
    end

    // Only the top byte of the data bus carries the terminate character.
    logic unused_data;
    assign unused_data = ^bus.i_gen_tx_data[DATA_WIDTH-9:0];

`ifdef MII_FRAME_SCHED_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(FRAME_TIMEOUT + 1);
    logic [WD_WIDTH-1:0] wd_cnt_reg;
    logic                timeout_reg;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(FRAME_TIMEOUT);
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg       <= S_IDLE;
            frame_count_reg <= '0;
            gap_reg         <= '0;
            gap_cnt_reg     <= '0;
            err_mode_reg    <= 8'h00;
            err_period_reg  <= 8'h00;
            err_cnt_reg     <= 8'h00;
            interrupt_reg   <= 8'h00;
            frames_sent_reg <= '0;
`ifdef MII_FRAME_SCHED_TIMEOUT_EN
            wd_cnt_reg      <= '0;
            timeout_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_enable) begin
                        frame_count_reg <= i_frame_count;
                        gap_reg         <= i_gap_cycles;
                        err_mode_reg    <= i_err_mode;
                        err_period_reg  <= i_err_period;
                        frames_sent_reg <= '0;
                        interrupt_reg   <= interrupt_next;
                        err_cnt_reg     <= err_cnt_next;
`ifdef MII_FRAME_SCHED_TIMEOUT_EN
                        timeout_reg     <= 1'b0;
`endif
                        state_reg       <= S_START;
                    end
                end

                S_START: begin
`ifdef MII_FRAME_SCHED_TIMEOUT_EN
                    wd_cnt_reg <= '0;
`endif
                    state_reg <= S_WAIT_EOF;
                end

                S_WAIT_EOF: begin
                    if (term_match) begin
                        frames_sent_reg <= frames_sent_next;
                        if (frame_count_reg != '0 && frames_sent_next == frame_count_reg) begin
                            state_reg <= S_DONE;
                        end else if (!i_enable) begin
                            // Graceful stop: the frame in flight has completed.
                            state_reg <= S_IDLE;
                        end else if (gap_reg == '0) begin
                            interrupt_reg <= interrupt_next;
                            err_cnt_reg   <= err_cnt_next;
                            state_reg     <= S_START;
                        end else begin
                            gap_cnt_reg <= gap_reg;
                            state_reg   <= S_GAP;
                        end
                    end
`ifdef MII_FRAME_SCHED_TIMEOUT_EN
                    else if (wd_cnt_reg == WD_WIDTH'(FRAME_TIMEOUT - 1)) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + WD_WIDTH'(1);
                    end
`endif
                end

                S_GAP: begin
                    // GAP is entered with the counter at gap, so the state
                    // lasts exactly gap cycles before the next start.
                    if (gap_cnt_reg == GAP_WIDTH'(1)) begin
                        if (i_enable) begin
                            interrupt_reg <= interrupt_next;
                            err_cnt_reg   <= err_cnt_next;
                            state_reg     <= S_START;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
                    end
                end

                S_DONE: begin
                    if (!i_enable) begin
                        state_reg <= S_IDLE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.o_start     = (state_reg == S_START);
    assign bus.o_interrupt = interrupt_reg;
    assign o_busy          = (state_reg == S_START) || (state_reg == S_WAIT_EOF) ||
                             (state_reg == S_GAP);
    assign o_done          = (state_reg == S_DONE);
    assign o_frames_sent   = frames_sent_reg;
`ifdef MII_FRAME_SCHED_TIMEOUT_EN
    assign o_timeout       = timeout_reg;
`else
    assign o_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_mii_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mii_frame_scheduler
//
// Self-checking bench for mii_frame_scheduler. A behavioural generator model
// answers every start pulse with a terminate block 74 cycles later. Expected
// start pulses (cycle and interrupt code) are queued when a run is launched
// and popped by a monitor whenever the DUT pulses o_start.
// ---------------------------------------------------------------------------
module tb_mii_frame_scheduler;

    localparam int DW  = 64;
    localparam int CW  = 8;
    localparam int CNT = 16;
    localparam int GW  = 8;
    localparam int FRAME_LEN = 74;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_enable;
    logic [CNT-1:0] i_frame_count;
    logic [GW-1:0]  i_gap_cycles;
    logic [7:0]     i_err_mode;
    logic [7:0]     i_err_period;
    logic           o_busy;
    logic           o_done;
    logic           o_timeout;
    logic [CNT-1:0] o_frames_sent;

    mii_frame_scheduler_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    mii_frame_scheduler #(
        .DATA_WIDTH    (DW),
        .CTRL_WIDTH    (CW),
        .TERMINATE_CODE(8'hFD),
        .CNT_WIDTH     (CNT),
        .GAP_WIDTH     (GW),
        .FRAME_TIMEOUT (128)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_frame_count(i_frame_count),
        .i_gap_cycles (i_gap_cycles),
        .i_err_mode   (i_err_mode),
        .i_err_period (i_err_period),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_frames_sent(o_frames_sent)
    );

    always #5 clk = ~clk;

    // cyc == k during the interval following the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("[TB] ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push_start(input int c, input logic [7:0] irq);
        exp_t e;
        e.cyc = c;
        e.irq = irq;
        exp_q.push_back(e);
    endtask

    // Generator model and start monitor, both on the falling edge.
    int term_at    = -1;
    bit never_term = 1'b0;
    bit prev_start = 1'b0;

    always @(negedge clk) begin
        if (i_rst === 1'b1) begin
            term_at = -1;
        end else if (bus.o_start === 1'b1 && !never_term) begin
            term_at = cyc + FRAME_LEN;
        end
        if (term_at == cyc) begin
            bus.i_gen_tx_data = {8'hFD, 56'h07070707070707};
            bus.i_gen_tx_ctrl = 8'h01;
        end else begin
            bus.i_gen_tx_data = {8{8'h07}};
            bus.i_gen_tx_ctrl = 8'hFF;
        end

        if (bus.o_start === 1'b1) begin
            check("start_not_back_to_back", 64'(prev_start), 64'd0);
            if (exp_q.size() == 0) begin
                check("start_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("start_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("start_irq", 64'(bus.o_interrupt), 64'(mon_e.irq));
            end
        end
        prev_start = (bus.o_start === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic launch(input logic [CNT-1:0] cnt, input logic [GW-1:0] gap,
                          input logic [7:0] mode, input logic [7:0] period);
        i_frame_count = cnt;
        i_gap_cycles  = gap;
        i_err_mode    = mode;
        i_err_period  = period;
        i_enable      = 1'b1;
    endtask

    int c0;
    int r;

    initial begin
        i_rst         = 1'b1;
        i_enable      = 1'b0;
        i_frame_count = '0;
        i_gap_cycles  = '0;
        i_err_mode    = 8'h00;
        i_err_period  = 8'h00;

        // Reset state.
        repeat (3) step();
        check("rst_start", 64'(bus.o_start), 64'd0);
        check("rst_irq", 64'(bus.o_interrupt), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_timeout", 64'(o_timeout), 64'd0);
        check("rst_frames", 64'(o_frames_sent), 64'd0);
        i_rst = 1'b0;
        step();

        // Run 1: count=3, gap=4 -> starts 79 cycles apart, done after 3rd terminate.
        c0 = cyc;
        launch(16'd3, 8'd4, 8'h00, 8'd0);
        push_start(c0 + 1, 8'h00);
        push_start(c0 + 80, 8'h00);
        push_start(c0 + 159, 8'h00);
        wait_until(c0 + 100);
        check("r1_busy_mid", 64'(o_busy), 64'd1);
        wait_until(c0 + 233);
        check("r1_done_early", 64'(o_done), 64'd0);
        check("r1_frames_pre", 64'(o_frames_sent), 64'd2);
        step();
        check("r1_done", 64'(o_done), 64'd1);
        check("r1_frames", 64'(o_frames_sent), 64'd3);
        check("r1_busy_done", 64'(o_busy), 64'd0);
        i_enable = 1'b0;
        step();
        check("r1_idle_done", 64'(o_done), 64'd0);
        check("r1_queue", 64'(exp_q.size()), 64'd0);

        // Run 2: count=2, gap=0 -> next start one cycle after terminate.
        c0 = cyc;
        launch(16'd2, 8'd0, 8'h00, 8'd0);
        push_start(c0 + 1, 8'h00);
        push_start(c0 + 76, 8'h00);
        wait_until(c0 + 150);
        check("r2_done_early", 64'(o_done), 64'd0);
        step();
        check("r2_done", 64'(o_done), 64'd1);
        check("r2_frames", 64'(o_frames_sent), 64'd2);
        i_enable = 1'b0;
        step();
        check("r2_queue", 64'(exp_q.size()), 64'd0);

        // Run 3: count=4, err_period=2, err_mode=02 -> 00,02,00,02.
        c0 = cyc;
        launch(16'd4, 8'd4, 8'h02, 8'd2);
        push_start(c0 + 1, 8'h00);
        push_start(c0 + 80, 8'h02);
        push_start(c0 + 159, 8'h00);
        push_start(c0 + 238, 8'h02);
        wait_until(c0 + 313);
        check("r3_done", 64'(o_done), 64'd1);
        check("r3_frames", 64'(o_frames_sent), 64'd4);
        check("r3_irq_held", 64'(bus.o_interrupt), 64'h02);
        i_enable = 1'b0;
        step();
        check("r3_queue", 64'(exp_q.size()), 64'd0);

        // Run 4: continuous, gap=2, drop enable during frame 5.
        c0 = cyc;
        launch(16'd0, 8'd2, 8'h00, 8'd0);
        for (int k = 0; k < 5; k++) push_start(c0 + 1 + 77 * k, 8'h00);
        wait_until(c0 + 340);
        i_enable = 1'b0;
        wait_until(c0 + 383);
        check("r4_busy_f5", 64'(o_busy), 64'd1);
        check("r4_frames_pre", 64'(o_frames_sent), 64'd4);
        step();
        check("r4_busy_idle", 64'(o_busy), 64'd0);
        check("r4_done", 64'(o_done), 64'd0);
        check("r4_frames", 64'(o_frames_sent), 64'd5);
        repeat (100) step();
        check("r4_queue", 64'(exp_q.size()), 64'd0);

        // Run 5: reset mid-frame, then a clean restart with enable still high.
        c0 = cyc;
        launch(16'd3, 8'd4, 8'h5A, 8'd1);
        push_start(c0 + 1, 8'h5A);
        wait_until(c0 + 30);
        check("r5_irq_pre", 64'(bus.o_interrupt), 64'h5A);
        i_rst = 1'b1;
        r = cyc;
        step();
        i_rst = 1'b0;
        check("r5_rst_start", 64'(bus.o_start), 64'd0);
        check("r5_rst_irq", 64'(bus.o_interrupt), 64'd0);
        check("r5_rst_busy", 64'(o_busy), 64'd0);
        check("r5_rst_done", 64'(o_done), 64'd0);
        check("r5_rst_frames", 64'(o_frames_sent), 64'd0);
        push_start(r + 2, 8'h5A);
        push_start(r + 81, 8'h5A);
        push_start(r + 160, 8'h5A);
        wait_until(r + 235);
        check("r5_done", 64'(o_done), 64'd1);
        check("r5_frames", 64'(o_frames_sent), 64'd3);
        i_enable = 1'b0;
        step();
        check("r5_queue", 64'(exp_q.size()), 64'd0);

`ifdef MII_FRAME_SCHED_TIMEOUT_EN
        // Run 6: generator never terminates -> watchdog abort after 128 cycles.
        never_term = 1'b1;
        c0 = cyc;
        launch(16'd1, 8'd0, 8'h00, 8'd0);
        push_start(c0 + 1, 8'h00);
        wait_until(c0 + 129);
        check("r6_done_early", 64'(o_done), 64'd0);
        check("r6_timeout_early", 64'(o_timeout), 64'd0);
        step();
        check("r6_done", 64'(o_done), 64'd1);
        check("r6_timeout", 64'(o_timeout), 64'd1);
        check("r6_frames", 64'(o_frames_sent), 64'd0);
        i_enable = 1'b0;
        step();
        check("r6_timeout_sticky", 64'(o_timeout), 64'd1);
        never_term = 1'b0;
        check("r6_queue", 64'(exp_q.size()), 64'd0);
`else
        check("timeout_tied_low", 64'(o_timeout), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mii_frame_scheduler.md
# mii_frame_scheduler

Sequencer for the 64-bit MII Ethernet frame generator. It issues single-cycle start pulses and per-frame interrupt codes. It detects end-of-frame by watching the generator's terminate block, inserts a programmable inter-frame gap, and stops after a programmed number of frames or runs continuously. It sits between the test or control register layer and the generator's `i_start`/`i_interrupt` inputs.

## Interface
- `DATA_WIDTH`, 64: generator data bus width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`: generator control bus width.
- `TERMINATE_CODE`, 8'hFD: terminate character expected in byte [63:56].
- `CNT_WIDTH`, 16: frame counter width.
- `GAP_WIDTH`, 8: gap counter width.
- `FRAME_TIMEOUT`, 128: maximum cycles allowed in WAIT_EOF before abort.
- `clk` in 1: clock; all logic on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_enable` in 1: run request; level-sensitive.
- `i_frame_count` in CNT_WIDTH: frames per run; 0 means continuous.
- `i_gap_cycles` in GAP_WIDTH: idle cycles between terminate detection and the next start.
- `i_err_mode` in 8: interrupt code driven during errored frames.
- `i_err_period` in 8: every Nth frame is errored; 0 means never.
- `i_gen_tx_data` in DATA_WIDTH: generator `o_tx_data`.
- `i_gen_tx_ctrl` in CTRL_WIDTH: generator `o_tx_ctrl`.
- `o_start` out 1: start pulse to the generator.
- `o_interrupt` out 8: interrupt code to the generator.
- `o_busy` out 1: high in every state except IDLE and DONE.
- `o_done` out 1: run completed normally or by timeout.
- `o_timeout` out 1: sticky flag; the run was aborted by the watchdog.
- `o_frames_sent` out CNT_WIDTH: terminates detected in the current run.

## Operation
- States: IDLE, START, WAIT_EOF, GAP, DONE.
- **IDLE**
  - If `i_enable`=1: latch `i_frame_count`, `i_gap_cycles`, `i_err_mode` and `i_err_period`; clear `o_frames_sent` and `o_timeout`; load err-countdown = `i_err_period`; go to START.
  - Otherwise stay in IDLE.
- **START** (exactly 1 cycle)
  - `o_start`=1.
  - `o_interrupt` = latched `err_mode` if `err_period`≠0 and err-countdown==1; otherwise 8'h00.
  - `o_interrupt` is held unchanged until the next START.
  - Update err-countdown: if it was 1, reload to `err_period`; otherwise decrement. Frames are numbered from 1, so the errored frames are `err_period`, 2·`err_period`, and so on.
  - Go to WAIT_EOF and clear the watchdog counter.
- **WAIT_EOF**
  - Terminate match: `i_gen_tx_ctrl`==8'h01 and `i_gen_tx_data[63:56]`==`TERMINATE_CODE`.
  - On a match:
    - Increment `o_frames_sent`; it wraps modulo 2^CNT_WIDTH in continuous mode.
    - If `frame_count`≠0 and the new count == `frame_count`, go to DONE.
    - Else if `i_enable`=0, go to IDLE (graceful stop; the frame always completes).
    - Else if `gap`==0, go to START.
    - Else go to GAP with gap counter = `gap`.
- **GAP**
  - Decrement the gap counter each cycle.
  - When the counter reaches 1: go to START if `i_enable`=1, else IDLE.
- **DONE**
  - `o_done`=1.
  - Hold until `i_enable`=0, then go to IDLE.
- Deasserting `i_enable` in START or WAIT_EOF does not abort the frame in flight.

## Timing
- Reset values: state=IDLE, `o_start`=0, `o_interrupt`=8'h00, `o_busy`=0, `o_done`=0, `o_timeout`=0, `o_frames_sent`=0. `i_rst` overrides all other inputs.
- `i_enable` sampled high at cycle 0 in IDLE → `o_start`=1 at cycle 1 → WAIT_EOF at cycle 2.
- Terminate seen at cycle T:
  - `o_frames_sent` updated at T+1.
  - With gap=N>0: GAP occupies T+1..T+N and `o_start`=1 at T+N+1.
  - With gap=0: `o_start`=1 at T+1.
- With the generator's fixed frame length, a frame's terminate appears 74 cycles after the `o_start` cycle.
- `o_start` is never high on two consecutive cycles.
- All outputs are registered or decoded directly from the state register; there are no input-to-output combinational paths.

## Configuration
- Macro: `MII_FRAME_SCHED_TIMEOUT_EN`.
- Defined:
  - A watchdog counts cycles in WAIT_EOF.
  - When the count reaches `FRAME_TIMEOUT` without a terminate: set `o_timeout`=1, go to DONE, and leave `o_frames_sent` unchanged.
- Undefined:
  - No watchdog logic is compiled in; `o_timeout` is tied to 0.
  - WAIT_EOF waits indefinitely.

## Test plan
- Count=3, gap=4, err_period=0, real generator attached:
  - 3 `o_start` pulses, 79 cycles apart.
  - `o_interrupt`=8'h00 throughout.
  - `o_done`=1 and `o_frames_sent`=3 one cycle after the third terminate.
- Count=2, gap=0: the second `o_start` occurs exactly 1 cycle after the first terminate block appears.
- Count=4, err_period=2, err_mode=8'h02: `o_interrupt` is 00, 02, 00, 02 for frames 1 to 4; frames 2 and 4 carry 8'h00 payload.
- Count=0 (continuous), drop `i_enable` mid-frame 5:
  - Frame 5 completes; no 6th start.
  - State returns to IDLE with `o_frames_sent`=5 and `o_done`=0.
- With the macro defined, a generator model that never terminates: `o_timeout`=1 and `o_done`=1 after 128 cycles in WAIT_EOF, and `o_frames_sent`=0.
- Assert `i_rst` for 1 cycle mid-frame: all outputs at reset values on the next cycle; a new run starts cleanly when `i_enable` is seen high.
